// File: rtl/wb_tohost_dmem.sv
// Wishbone classic data memory with byte-lane writes, programmable wait states,
// a tohost completion mailbox and a post-reset watchdog.
//
// state | meaning
// IDLE  | waiting for a request; latches address, we, sel, data
// WAIT  | counting wait states; aborts if cyc or stb drops
// RESP  | ack or err high for exactly this cycle
module wb_tohost_dmem #(
  parameter int    ADDR_WIDTH     = 13,
  parameter int    WAIT_STATES    = 0,
  parameter int    TOHOST_WORD    = 1024,
  parameter int    TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [30:0] fail_code_o,
  output logic        timeout_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WDW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDW-1:0]        WD_LAST    = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]            WS_LAST    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] TOHOST_IDX = ADDR_WIDTH'(TOHOST_WORD);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      wcnt;
  logic [WDW-1:0]  wdog;
  logic [31:2]     adr_q;
  logic [31:0]     dat_q;
  logic            we_q;
  logic [3:0]      sel_q;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic [31:2]           cur_adr;
  logic [31:0]           cur_dat;
  logic                  cur_we;
  logic [3:0]            cur_sel;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  cur_in;
  logic                  finish;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  wr_en;
  logic                  set_done;

  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  // With zero wait states the response is raised on the accepting edge, so
  // the live bus fields are used in IDLE and the latched copy elsewhere.
  always_comb begin
    cur_adr = adr_q;
    cur_dat = dat_q;
    cur_we  = we_q;
    cur_sel = sel_q;
    if (state == IDLE) begin
      cur_adr = wb_adr_i[31:2];
      cur_dat = wb_dat_i;
      cur_we  = wb_we_i;
      cur_sel = wb_sel_i;
    end
  end

  assign cur_idx  = cur_adr[ADDR_WIDTH+1:2];
  assign cur_in   = (cur_adr[31:ADDR_WIDTH+2] == '0);
  assign finish   = (state == IDLE && req && WAIT_STATES == 0) ||
                    (state == WAIT && wb_cyc_i && wb_stb_i && wcnt == WS_LAST);
  assign old_word = mem[cur_idx];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (cur_sel[i]) merged[8*i +: 8] = cur_dat[8*i +: 8];
    end
  end

  assign wr_en    = finish & cur_we & cur_in;
  assign set_done = wr_en && (cur_idx == TOHOST_IDX) && (merged != 32'd0) &&
                    !done_o && !timeout_o;

  always_ff @(posedge clk) begin
    if (wr_en) mem[cur_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= 4'd0;
      wdog        <= '0;
      adr_q       <= '0;
      dat_q       <= 32'd0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= 32'd0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_code_o <= 31'd0;
      timeout_o   <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;

      case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wb_adr_i[31:2];
            dat_q <= wb_dat_i;
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            wcnt  <= 4'd0;
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!wb_cyc_i || !wb_stb_i) state <= IDLE;
          else if (wcnt == WS_LAST)   state <= RESP;
          else                        wcnt  <= wcnt + 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (finish) begin
        if (cur_in) begin
          wb_ack_o <= 1'b1;
          wb_dat_o <= mem[cur_idx];
        end else begin
          wb_err_o <= 1'b1;
        end
      end

      if (set_done) begin
        done_o      <= 1'b1;
        pass_o      <= (merged == 32'd1);
        fail_code_o <= (merged == 32'd1) ? 31'd0 : merged[31:1];
      end

      // A tohost completion on the same edge wins over watchdog expiry.
      if (!done_o && !timeout_o && !set_done) begin
        if (wdog == WD_LAST) timeout_o <= 1'b1;
        else                 wdog      <= wdog + WDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_tohost_dmem.sv
// Directed bench for wb_tohost_dmem: three instances (0 wait states, 3 wait
// states, 50-cycle watchdog) checked against a scoreboard and a word model.
`timescale 1ns/1ps
module tb_wb_tohost_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] adr, wdat;
  logic        we;
  logic [3:0]  sel;
  logic        cyc0, stb0, cyc3, stb3, cyct, stbt;

  logic [31:0] dat0, dat3, datt;
  logic        ack0, ack3, ackt, err0, err3, errt;
  logic        done0, done3, donet, pass0, pass3, passt, to0, to3, tot;
  logic [30:0] code0, code3, codet;

  wb_tohost_dmem #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat0),
    .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
    .wb_ack_o(ack0), .wb_err_o(err0), .done_o(done0), .pass_o(pass0),
    .fail_code_o(code0), .timeout_o(to0));

  wb_tohost_dmem #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat3),
    .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc3), .wb_stb_i(stb3),
    .wb_ack_o(ack3), .wb_err_o(err3), .done_o(done3), .pass_o(pass3),
    .fail_code_o(code3), .timeout_o(to3));

  wb_tohost_dmem #(.WAIT_STATES(0), .TIMEOUT_CYCLES(50)) ut (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(datt),
    .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyct), .wb_stb_i(stbt),
    .wb_ack_o(ackt), .wb_err_o(errt), .done_o(donet), .pass_o(passt),
    .fail_code_o(codet), .timeout_o(tot));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m0[int];
  logic [31:0] m3[int];
  logic [31:0] mt[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_rd(input int u, input int idx);
    case (u)
      0:       return m0.exists(idx) ? m0[idx] : 32'd0;
      3:       return m3.exists(idx) ? m3[idx] : 32'd0;
      default: return mt.exists(idx) ? mt[idx] : 32'd0;
    endcase
  endfunction

  task automatic model_wr(input int u, input int idx, input logic [31:0] v);
    case (u)
      0:       m0[idx] = v;
      3:       m3[idx] = v;
      default: mt[idx] = v;
    endcase
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic set_req(input int u, input logic v);
    case (u)
      0:       begin cyc0 = v; stb0 = v; end
      3:       begin cyc3 = v; stb3 = v; end
      default: begin cyct = v; stbt = v; end
    endcase
  endtask

  function automatic logic get_ack(input int u);
    case (u) 0: return ack0; 3: return ack3; default: return ackt; endcase
  endfunction
  function automatic logic get_err(input int u);
    case (u) 0: return err0; 3: return err3; default: return errt; endcase
  endfunction
  function automatic logic [31:0] get_dat(input int u);
    case (u) 0: return dat0; 3: return dat3; default: return datt; endcase
  endfunction

  // One bus transfer: push the expectation, drive, wait for ack/err, pop and compare.
  task automatic xfer(input int u, input string tag, input logic [31:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d);
    exp_t        e;
    int          n;
    logic        got;
    logic        inr;
    int          idx;
    inr    = (a[31:15] == 17'd0);
    idx    = int'(a[14:2]);
    e.err  = !inr;
    e.rd   = !w;
    e.lat  = (u == 3) ? 4 : 1;
    e.data = inr ? model_rd(u, idx) : 32'd0;
    sb.push_back(e);
    @(negedge clk);
    adr = a; wdat = d; we = w; sel = s;
    set_req(u, 1'b1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = get_ack(u) | get_err(u);
    end
    e = sb.pop_front();
    chk({tag, "_resp"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      chk({tag, "_err"}, {31'd0, get_err(u)}, {31'd0, e.err});
      chk({tag, "_ack"}, {31'd0, get_ack(u)}, {31'd0, !e.err});
      if (e.rd || e.err) chk({tag, "_data"}, get_dat(u), e.data);
      if (w && !e.err) model_wr(u, idx, merge(model_rd(u, idx), d, s));
    end
    set_req(u, 1'b0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, get_ack(u) | get_err(u)}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b0); set_req(3, 1'b0); set_req(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: observed no finish, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    int acks;
    rst_n = 1'b0;
    adr = 32'd0; wdat = 32'd0; we = 1'b0; sel = 4'd0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; cyct = 1'b0; stbt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",  {31'd0, ack0}, 32'd0);
    chk("rst_err",  {31'd0, err0}, 32'd0);
    chk("rst_dat",  dat0, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_pass", {31'd0, pass0}, 32'd0);
    chk("rst_code", {1'b0, code0}, 32'd0);
    chk("rst_to",   {31'd0, to0}, 32'd0);
    rst_n = 1'b1;

    // Zero-wait-state read/write and lane merge
    xfer(0, "w200",   32'h200, 1'b1, 4'b1111, 32'hDEADBEEF);
    xfer(0, "r200",   32'h200, 1'b0, 4'b1111, 32'h0);
    xfer(0, "w200b1", 32'h200, 1'b1, 4'b0010, 32'h0000AA00);
    xfer(0, "r200m",  32'h200, 1'b0, 4'b0000, 32'h0);
    chk("merge_model", model_rd(0, 32'h200 >> 2), 32'hDEADAAEF);
    xfer(0, "wsel0",  32'h200, 1'b1, 4'b0000, 32'h12345678);
    xfer(0, "rsel0",  32'h200, 1'b0, 4'b1111, 32'h0);

    // Held request: one ack every two cycles
    @(negedge clk);
    adr = 32'h200; we = 1'b0; sel = 4'b1111;
    set_req(0, 1'b1);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(ack0);
    end
    set_req(0, 1'b0);
    chk("b2b_acks", 32'(acks), 32'd3);

    // tohost pass, then frozen flags
    xfer(0, "th_pass", 32'h1000, 1'b1, 4'b1111, 32'h1);
    chk("th_pass_done", {31'd0, done0}, 32'd1);
    chk("th_pass_pass", {31'd0, pass0}, 32'd1);
    chk("th_pass_code", {1'b0, code0}, 32'd0);
    xfer(0, "th_late", 32'h1000, 1'b1, 4'b1111, 32'h7);
    chk("th_late_done", {31'd0, done0}, 32'd1);
    chk("th_late_pass", {31'd0, pass0}, 32'd1);
    chk("th_late_code", {1'b0, code0}, 32'd0);
    xfer(0, "th_late_rd", 32'h1000, 1'b0, 4'b1111, 32'h0);

    // tohost zero write, then fail code
    do_reset();
    xfer(0, "th_zero", 32'h1000, 1'b1, 4'b1111, 32'h0);
    chk("th_zero_done", {31'd0, done0}, 32'd0);
    xfer(0, "th_fail", 32'h1000, 1'b1, 4'b1111, 32'h9);
    chk("th_fail_done", {31'd0, done0}, 32'd1);
    chk("th_fail_pass", {31'd0, pass0}, 32'd0);
    chk("th_fail_code", {1'b0, code0}, 32'd4);

    // Out-of-range access
    xfer(0, "w0",     32'h0,    1'b1, 4'b1111, 32'hA5A5A5A5);
    xfer(0, "w_oor",  32'h8000, 1'b1, 4'b1111, 32'hFFFFFFFF);
    xfer(0, "r_oor",  32'h8000, 1'b0, 4'b1111, 32'h0);
    xfer(0, "r0",     32'h0,    1'b0, 4'b1111, 32'h0);
    chk("oor_code", {1'b0, code0}, 32'd4);

    // Three wait states, abort
    xfer(3, "ws_w0", 32'h0, 1'b1, 4'b1111, 32'h00000013);
    xfer(3, "ws_r0", 32'h0, 1'b0, 4'b1111, 32'h0);
    @(negedge clk);
    adr = 32'h0; wdat = 32'hFFFFFFFF; we = 1'b1; sel = 4'b1111;
    set_req(3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    set_req(3, 1'b0);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(ack3 | err3);
    end
    chk("abort_noack", 32'(acks), 32'd0);
    xfer(3, "abort_r0", 32'h0, 1'b0, 4'b1111, 32'h0);

    // tohost value is the post-merge word
    xfer(3, "mg_zero", 32'h1000, 1'b1, 4'b1111, 32'h0);
    chk("mg_zero_done", {31'd0, done3}, 32'd0);
    xfer(3, "mg_lane", 32'h1000, 1'b1, 4'b0001, 32'hFFFFFF03);
    chk("mg_done", {31'd0, done3}, 32'd1);
    chk("mg_pass", {31'd0, pass3}, 32'd0);
    chk("mg_code", {1'b0, code3}, 32'd1);

    // Reset during a wait-stated write
    xfer(3, "rs_init", 32'h40, 1'b1, 4'b1111, 32'h11111111);
    @(negedge clk);
    adr = 32'h40; wdat = 32'h22222222; we = 1'b1; sel = 4'b1111;
    set_req(3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_ack",   {31'd0, ack3}, 32'd0);
    chk("rs_done3", {31'd0, done3}, 32'd0);
    chk("rs_code3", {1'b0, code3}, 32'd0);
    chk("rs_done0", {31'd0, done0}, 32'd0);
    chk("rs_code0", {1'b0, code0}, 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(ack3);
    end
    set_req(3, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      acks += int'(ack3);
    end
    chk("rs_noack", 32'(acks), 32'd0);
    xfer(3, "rs_rd", 32'h40, 1'b0, 4'b1111, 32'h0);

    // Watchdog: expires on the 50th edge after reset release
    do_reset();
    repeat (49) @(negedge clk);
    chk("wd_49", {31'd0, tot}, 32'd0);
    @(negedge clk);
    chk("wd_50", {31'd0, tot}, 32'd1);
    xfer(2, "wd_pass", 32'h1000, 1'b1, 4'b1111, 32'h1);
    chk("wd_done", {31'd0, donet}, 32'd0);
    chk("wd_pass_flag", {31'd0, passt}, 32'd0);
    chk("wd_sticky", {31'd0, tot}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
